colouring_search_engine: RTL and testbench

Parametrised brute-force graph-colouring engine, the general successor to the fixed nine-vertex solver in the synthesis-trap hardware. The graph is loaded at run time as an adjacency matrix. The engine enumerates every assignment of `COLOURS` colours to `NODES` vertices, one candidate per cycle. Each valid colouring is streamed out over a valid/ready handshake, and the search then resumes, so the engine finds all solutions rather than stopping at the first. It also keeps a solution count and supports abort.

---
 rtl/colouring_pkg.sv | 28 ++
 rtl/colour_digit_counter.sv | 65 ++++++
 rtl/colouring_param_checker.sv | 15 +
 rtl/colouring_search_engine.sv | 186 ++++++++++++++++++
 tb/tb_colouring_search_engine.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/colouring_pkg.sv
// Shared types and helpers for colouring_search_engine: FSM states, colour-digit
// width derivation and the legal parameter range.
package colouring_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SEARCH   = 2'd1,
        REPORT   = 2'd2,
        FINISHED = 2'd3
    } state_e;

    // Bits needed to hold one colour digit; two colours still need one bit.
    function automatic int colour_width(input int colours);
        int w;
        if (colours <= 32'sd2) begin
            w = 32'sd1;
        end else begin
            w = $clog2(colours);
        end
        return w;
    endfunction

    function automatic bit params_ok(input int nodes, input int colours);
        return (nodes >= 32'sd2) && (nodes <= 32'sd16) &&
               (colours >= 32'sd2) && (colours <= 32'sd4);
    endfunction

endpackage

// File: rtl/colour_digit_counter.sv
// Mixed-radix colour-digit counter, digit 0 least significant.
// With COLOURING_SYMMETRY_BREAK_EN defined, digit 0 is pinned to colour 0.
module colour_digit_counter #(
    parameter int NODES   = 9,
    parameter int COLOURS = 3,
    parameter int CW      = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                clear,
    input  logic                advance,
    output logic [NODES*CW-1:0] digits,
    output logic                last
);

`ifdef COLOURING_SYMMETRY_BREAK_EN
    localparam int FIRST = 1;
`else
    localparam int FIRST = 0;
`endif
    localparam logic [CW-1:0] MAX_DIGIT = CW'(COLOURS - 1);
    localparam logic [CW-1:0] ONE_DIGIT = CW'(1'b1);

    logic [NODES*CW-1:0] digits_r;
    logic [NODES*CW-1:0] digits_nxt_s;
    logic                carry_s;
    logic                last_s;

    // Ripple increment over the active digits and detection of the final candidate
    always_comb begin
        digits_nxt_s = digits_r;
        carry_s      = 1'b1;
        last_s       = 1'b1;
        for (int i = FIRST; i < NODES; i++) begin
            last_s = last_s & (digits_r[i*CW +: CW] == MAX_DIGIT);
            if (carry_s) begin
                if (digits_r[i*CW +: CW] == MAX_DIGIT) begin
                    digits_nxt_s[i*CW +: CW] = '0;
                end else begin
                    digits_nxt_s[i*CW +: CW] = digits_r[i*CW +: CW] + ONE_DIGIT;
                    carry_s                  = 1'b0;
                end
            end else begin
                digits_nxt_s[i*CW +: CW] = digits_r[i*CW +: CW];
            end
        end
    end

    // Digit register: cleared at search start, stepped on request
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            digits_r <= '0;
        end else if (clear) begin
            digits_r <= '0;
        end else if (advance) begin
            digits_r <= digits_nxt_s;
        end else begin
            digits_r <= digits_r;
        end
    end

    assign digits = digits_r;
    assign last   = last_s;

endmodule

// File: rtl/colouring_param_checker.sv
// Elaboration-time range check on the engine's NODES/COLOURS parameters.
module colouring_param_checker
    import colouring_pkg::*;
#(
    parameter int NODES   = 9,
    parameter int COLOURS = 3
) ();

    generate
        if (!params_ok(NODES, COLOURS)) begin : g_range_error
            $error("colouring_search_engine: NODES must be 2..16 and COLOURS 2..4");
        end
    endgenerate

endmodule

// File: rtl/colouring_search_engine.sv
// Brute-force graph-colouring engine: streams every valid colouring of a run-time
// adjacency matrix. Optional COLOURING_SYMMETRY_BREAK_EN pins vertex 0 to colour 0.
module colouring_search_engine
    import colouring_pkg::*;
#(
    parameter int NODES   = 9,
    parameter int COLOURS = 3,
    parameter int CW      = colour_width(COLOURS),
    parameter int CNT_W   = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic [NODES*NODES-1:0] adj,
    output logic                   busy,
    output logic                   sol_valid,
    input  logic                   sol_ready,
    output logic [NODES*CW-1:0]    colouring,
    output logic [CNT_W-1:0]       sol_count,
    output logic                   done,
    output logic                   exhausted
);

    localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1'b1);

    state_e                 state_r, state_nxt_s;
    logic [NODES*NODES-1:0] adj_r;
    logic [NODES*CW-1:0]    digits_s;
    logic                   last_s;
    logic                   conflict_s;
    logic                   load_s, clear_s, advance_s;
    logic                   busy_r, busy_nxt_s;
    logic                   sol_valid_r, sol_valid_nxt_s;
    logic [NODES*CW-1:0]    colouring_r, colouring_nxt_s;
    logic [CNT_W-1:0]       sol_count_r, sol_count_nxt_s;
    logic                   done_r, done_nxt_s;
    logic                   exhausted_r, exhausted_nxt_s;

    colouring_param_checker #(
        .NODES   (NODES),
        .COLOURS (COLOURS)
    ) u_param_check ();

    colour_digit_counter #(
        .NODES   (NODES),
        .COLOURS (COLOURS),
        .CW      (CW)
    ) u_digits (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (clear_s),
        .advance (advance_s),
        .digits  (digits_s),
        .last    (last_s)
    );

    // Edge checker: an edge in either triangle of the matrix constrains the pair
    always_comb begin
        conflict_s = 1'b0;
        for (int i = 0; i < NODES; i++) begin
            for (int j = i + 1; j < NODES; j++) begin
                conflict_s = conflict_s |
                    ((adj_r[i*NODES+j] | adj_r[j*NODES+i]) &
                     (digits_s[i*CW +: CW] == digits_s[j*CW +: CW]));
            end
        end
    end

    // Search FSM next-state and next-output logic; abort always has priority
    always_comb begin
        state_nxt_s     = state_r;
        sol_valid_nxt_s = sol_valid_r;
        colouring_nxt_s = colouring_r;
        sol_count_nxt_s = sol_count_r;
        done_nxt_s      = done_r;
        exhausted_nxt_s = exhausted_r;
        load_s          = 1'b0;
        clear_s         = 1'b0;
        advance_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    load_s          = 1'b1;
                    clear_s         = 1'b1;
                    sol_count_nxt_s = '0;
                    done_nxt_s      = 1'b0;
                    exhausted_nxt_s = 1'b0;
                    state_nxt_s     = SEARCH;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SEARCH: begin
                if (abort) begin
                    state_nxt_s     = FINISHED;
                    done_nxt_s      = 1'b1;
                    exhausted_nxt_s = 1'b0;
                    sol_valid_nxt_s = 1'b0;
                end else if (!conflict_s) begin
                    colouring_nxt_s = digits_s;
                    sol_valid_nxt_s = 1'b1;
                    state_nxt_s     = REPORT;
                end else if (last_s) begin
                    state_nxt_s     = FINISHED;
                    done_nxt_s      = 1'b1;
                    exhausted_nxt_s = 1'b1;
                end else begin
                    advance_s = 1'b1;
                end
            end
            REPORT: begin
                if (abort) begin
                    state_nxt_s     = FINISHED;
                    done_nxt_s      = 1'b1;
                    exhausted_nxt_s = 1'b0;
                    sol_valid_nxt_s = 1'b0;
                end else if (sol_ready) begin
                    sol_valid_nxt_s = 1'b0;
                    sol_count_nxt_s = (sol_count_r == '1) ? sol_count_r : sol_count_r + ONE_CNT;
                    if (last_s) begin
                        state_nxt_s     = FINISHED;
                        done_nxt_s      = 1'b1;
                        exhausted_nxt_s = 1'b1;
                    end else begin
                        advance_s   = 1'b1;
                        state_nxt_s = SEARCH;
                    end
                end else begin
                    state_nxt_s = REPORT;
                end
            end
            FINISHED: begin
                if (!start) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = FINISHED;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
        busy_nxt_s = (state_nxt_s == SEARCH) || (state_nxt_s == REPORT);
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= IDLE;
            busy_r      <= 1'b0;
            sol_valid_r <= 1'b0;
            colouring_r <= '0;
            sol_count_r <= '0;
            done_r      <= 1'b0;
            exhausted_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            busy_r      <= busy_nxt_s;
            sol_valid_r <= sol_valid_nxt_s;
            colouring_r <= colouring_nxt_s;
            sol_count_r <= sol_count_nxt_s;
            done_r      <= done_nxt_s;
            exhausted_r <= exhausted_nxt_s;
        end
    end

    // Graph snapshot taken when a start is accepted
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            adj_r <= '0;
        end else if (load_s) begin
            adj_r <= adj;
        end else begin
            adj_r <= adj_r;
        end
    end

    assign busy      = busy_r;
    assign sol_valid = sol_valid_r;
    assign colouring = colouring_r;
    assign sol_count = sol_count_r;
    assign done      = done_r;
    assign exhausted = exhausted_r;

endmodule

// File: tb/tb_colouring_search_engine.sv
// Scoreboard bench for colouring_search_engine (4 nodes, 3 colours, 3-bit counter).
module tb_colouring_search_engine;

    localparam int N    = 4;
    localparam int C    = 3;
    localparam int W    = 2;
    localparam int CNTW = 3;
    localparam int CMAX = 7;
`ifdef COLOURING_SYMMETRY_BREAK_EN
    localparam int SB = 1;
`else
    localparam int SB = 0;
`endif

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic           start = 1'b0;
    logic           abort = 1'b0;
    logic           sol_ready = 1'b0;
    logic [N*N-1:0] adj = '0;
    logic           busy, sol_valid, done, exhausted;
    logic [N*W-1:0] colouring;
    logic [CNTW-1:0] sol_count;

    colouring_search_engine #(.NODES(N), .COLOURS(C), .CNT_W(CNTW)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .adj(adj),
        .busy(busy), .sol_valid(sol_valid), .sol_ready(sol_ready),
        .colouring(colouring), .sol_count(sol_count), .done(done), .exhausted(exhausted)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N*W-1:0] col;
        int             idx;
    } exp_t;

    exp_t           exp_q[$];
    exp_t           mon_e;
    int             n_cmp = 0;
    int             n_fail = 0;
    int             exp_total, exp_nsol;
    bit             mon_en = 1'b0;
    int             search_cyc, acc_cnt;
    bit             pres, abort_pend, abort_chk, done_seen;
    logic [N*W-1:0] pres_col;

    function automatic void chk(input string nm, input longint act, input longint expv);
        n_cmp++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, expv);
        end
    endfunction

    // Reference: walk candidate numbers, decode digits by division, keep proper colourings
    function automatic void build_model(input logic [N*N-1:0] g);
        int total;
        total = 1;
        exp_q.delete();
        for (int i = SB; i < N; i++) total = total * C;
        exp_total = total;
        exp_nsol  = 0;
        for (int k = 0; k < total; k++) begin
            int   d[N];
            int   t;
            bit   ok;
            exp_t e;
            t  = k;
            ok = 1'b1;
            for (int i = 0; i < N; i++) d[i] = 0;
            for (int i = SB; i < N; i++) begin
                d[i] = t % C;
                t    = t / C;
            end
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++)
                    if (i != j && g[i*N+j] && d[i] == d[j]) ok = 1'b0;
            if (ok) begin
                e.col = '0;
                for (int i = 0; i < N; i++) e.col[i*W +: W] = 2'(d[i]);
                e.idx = k;
                exp_q.push_back(e);
                exp_nsol++;
            end
        end
    endfunction

    // Monitor: pops expectations when a colouring is presented, tracks handshakes
    always @(negedge clk) begin
        if (mon_en) begin
            if (abort_chk) begin
                chk("abort_to_done", done, 1);
                abort_chk = 1'b0;
            end
            if (busy && !sol_valid) search_cyc++;
            if (sol_valid && !pres) begin
                pres     = 1'b1;
                pres_col = colouring;
                chk("queue_nonempty", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    mon_e = exp_q.pop_front();
                    chk("colouring", colouring, mon_e.col);
                    chk("search_cycle", search_cyc, mon_e.idx + 1);
                end
            end else if (sol_valid) begin
                chk("colouring_stable", colouring, pres_col);
            end
            if (busy) chk("sol_count_live", sol_count, acc_cnt);
            if (busy && abort) begin
                abort_pend = 1'b1;
                abort_chk  = 1'b1;
                pres       = 1'b0;
            end else if (sol_valid && sol_ready) begin
                acc_cnt = (acc_cnt == CMAX) ? CMAX : acc_cnt + 1;
                pres    = 1'b0;
            end
            if (done && !done_seen) begin
                done_seen = 1'b1;
                chk("exhausted", exhausted, !abort_pend);
                chk("sol_valid_at_done", sol_valid, 0);
                chk("busy_at_done", busy, 0);
                if (abort_pend) begin
                    chk("count_after_abort", sol_count, acc_cnt);
                end else begin
                    chk("count_final", sol_count, (exp_nsol > CMAX) ? CMAX : exp_nsol);
                    chk("leftover_solutions", exp_q.size(), 0);
                    chk("search_cycles", search_cyc, exp_total);
                end
            end
        end
    end

    // Modes: 0 ready=1, 1 random ready, 2 five-cycle stall, 3 abort+ready in REPORT,
    // 4 abort at a random cycle, 5 start pulse mid-search
    task automatic run(input logic [N*N-1:0] g, input int mode, input int abort_at,
                       output int edges);
        bit fired;
        int stall;
        fired = 1'b0;
        stall = 0;
        edges = 0;
        build_model(g);
        adj = g;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        search_cyc = 0; acc_cnt = 0; pres = 1'b0;
        abort_pend = 1'b0; abort_chk = 1'b0; done_seen = 1'b0; mon_en = 1'b1;
        while (done !== 1'b1 && edges < 3000) begin
            abort = 1'b0;
            start = 1'b0;
            sol_ready = ($urandom_range(1, 0) == 1);
            if (mode == 0 || mode == 3) sol_ready = 1'b1;
            if (mode == 2) begin
                if (!sol_valid) stall = 0;
                if (sol_valid && stall < 5) begin
                    sol_ready = 1'b0;
                    stall++;
                end else begin
                    sol_ready = 1'b1;
                end
            end
            if (mode == 3 && sol_valid && acc_cnt >= 1 && !fired) begin
                abort = 1'b1;
                fired = 1'b1;
            end
            if (mode == 4 && edges == abort_at) abort = 1'b1;
            if (mode == 5 && edges == 10) start = 1'b1;
            @(posedge clk); #1;
            edges++;
        end
        abort = 1'b0; start = 1'b0; sol_ready = 1'b0;
        chk("done_within_budget", done, 1);
        @(posedge clk); #1;
        chk("done_reported", done_seen, 1);
        if (mode == 0) chk("run_length", edges, exp_total + exp_nsol);
        if (mode == 2) chk("run_length_stall", edges, exp_total + 6 * exp_nsol);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [N*N-1:0] tri_g, k4_g;
        int             e;
        tri_g = 16'h8467;
        k4_g  = 16'h8CFD;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_sol_valid", sol_valid, 0);
        chk("rst_colouring", colouring, 0);
        chk("rst_sol_count", sol_count, 0);
        chk("rst_done", done, 0);
        chk("rst_exhausted", exhausted, 0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        run(k4_g, 0, 0, e);
        chk("k4_no_solutions", exp_nsol, 0);
        run(tri_g, 0, 0, e);
        run(tri_g, 2, 0, e);
        run(tri_g, 3, 0, e);
        run(tri_g, 5, 0, e);

        mon_en = 1'b0;
        adj = tri_g;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0; sol_ready = 1'b1;
        repeat (20) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_sol_valid", sol_valid, 0);
        chk("midrst_colouring", colouring, 0);
        chk("midrst_sol_count", sol_count, 0);
        chk("midrst_done", done, 0);
        chk("midrst_exhausted", exhausted, 0);
        sol_ready = 1'b0;
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;
        run(tri_g, 0, 0, e);

        for (int r = 0; r < 10; r++) begin
            run(16'($urandom), int'($urandom_range(5, 0)), int'($urandom_range(120, 1)), e);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
